// File: rtl/sie_pkg.sv
// Shared definitions for the Serial Interface Engine receive path.
//   STUFF_RUN_LEN : run of consecutive 1s after which the next bit is a stuff bit
//   cnt_width()   : bit-counter width needed to count 0..data_w
//   bit_cnt_t     : bit-count type wide enough for the largest supported word
//   ones_cnt_t    : ones-run counter type used by the bit unstuffer
package sie_pkg;

  localparam int unsigned STUFF_RUN_LEN = 6;
  localparam int unsigned MAX_DATA_W    = 32;

  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

  typedef logic [$clog2(MAX_DATA_W + 1)-1:0]    bit_cnt_t;
  typedef logic [$clog2(STUFF_RUN_LEN + 1)-1:0] ones_cnt_t;

endpackage

// File: rtl/sipo_deser_if.sv
// Bus between bit recovery, the deserializer and the packet decoder.
//   SER_IP/SER_VLD/FRM_START : serial side (bit recovery -> deserializer)
//   PAR_OP/PAR_VLD/PAR_RDY   : parallel word handshake (deserializer <-> decoder)
//   OVERRUN/STUFF_ERR        : status flags from the deserializer
// Modports: slave = deserializer view, master = driver/consumer view.
interface sipo_deser_if #(
  parameter int unsigned DATA_W = 8
);

  logic              SER_IP;
  logic              SER_VLD;
  logic              FRM_START;
  logic [DATA_W-1:0] PAR_OP;
  logic              PAR_VLD;
  logic              PAR_RDY;
  logic              OVERRUN;
  logic              STUFF_ERR;

  modport slave (
    input  SER_IP, SER_VLD, FRM_START, PAR_RDY,
    output PAR_OP, PAR_VLD, OVERRUN, STUFF_ERR
  );

  modport master (
    output SER_IP, SER_VLD, FRM_START, PAR_RDY,
    input  PAR_OP, PAR_VLD, OVERRUN, STUFF_ERR
  );

endinterface

// File: rtl/sie_bit_unstuff.sv
// USB bit unstuffer for the deserializer input stream.
// Only built when SIPO_BIT_UNSTUFF_EN is defined.
//   clk, rst    : clock, async active-high reset
//   ser_ip      : serial bit
//   ser_vld     : ser_ip valid this cycle
//   frm_start   : frame alignment, clears the ones run
//   bit_vld     : ser_ip is a data bit to be shifted (comb)
//   word_drop   : stuff violation this cycle, discard the partial word (comb)
//   stuff_err   : registered one-cycle pulse after a stuff violation
`ifdef SIPO_BIT_UNSTUFF_EN
module sie_bit_unstuff
  import sie_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ser_ip,
  input  logic ser_vld,
  input  logic frm_start,
  output logic bit_vld,
  output logic word_drop,
  output logic stuff_err
);

  ones_cnt_t ones_q, ones_d, ones_base;
  logic      err_q, err_d;

  always_comb begin
    ones_d    = ones_q;
    err_d     = 1'b0;
    bit_vld   = 1'b0;
    word_drop = 1'b0;
    // Frame alignment restarts the run before the current bit is judged.
    ones_base = frm_start ? '0 : ones_q;
    if (frm_start) begin
      ones_d = '0;
    end
    if (ser_vld) begin
      if (ones_base == ones_cnt_t'(STUFF_RUN_LEN)) begin
        ones_d = '0;
        if (ser_ip) begin
          err_d     = 1'b1;
          word_drop = 1'b1;
        end
      end else begin
        bit_vld = 1'b1;
        ones_d  = ser_ip ? ones_base + ones_cnt_t'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ones_q <= ones_d;
      err_q  <= err_d;
    end
  end

  assign stuff_err = err_q;

endmodule
`endif

// File: rtl/sipo_deser.sv
// Parametrised serial-to-parallel deserializer with a one-word holding
// register, valid/ready handshake and sticky overrun flag.
// Parameters: DATA_W (2..32) word width; LSB_FIRST 1 = first bit -> PAR_OP[0].
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : sipo_deser_if.slave (SER_IP, SER_VLD, FRM_START, PAR_RDY in;
//              PAR_OP, PAR_VLD, OVERRUN, STUFF_ERR out)
// Optional feature: define SIPO_BIT_UNSTUFF_EN to insert USB bit unstuffing
// (sie_bit_unstuff); otherwise every valid bit is data and STUFF_ERR is 0.
module sipo_deser
  import sie_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  sipo_deser_if.slave bus
);

  localparam int unsigned CNT_W     = cnt_width(DATA_W);
  localparam bit_cnt_t    WORD_LAST = bit_cnt_t'(DATA_W - 1);

  logic [DATA_W-1:0] shift_q, shift_d, shift_base, shift_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
  logic [DATA_W-1:0] par_op_q, par_op_d;
  logic              par_vld_q, par_vld_d;
  logic              overrun_q, overrun_d;
  logic              bit_vld, word_drop, stuff_err;

`ifdef SIPO_BIT_UNSTUFF_EN
  sie_bit_unstuff u_unstuff (
    .clk       (CLK),
    .rst       (RST),
    .ser_ip    (bus.SER_IP),
    .ser_vld   (bus.SER_VLD),
    .frm_start (bus.FRM_START),
    .bit_vld   (bit_vld),
    .word_drop (word_drop),
    .stuff_err (stuff_err)
  );
`else
  assign bit_vld   = bus.SER_VLD;
  assign word_drop = 1'b0;
  assign stuff_err = 1'b0;
`endif

  always_comb begin
    par_op_d  = par_op_q;
    par_vld_d = par_vld_q;
    overrun_d = overrun_q;
    // FRM_START realigns first; a bit sampled in the same cycle starts the new word.
    shift_base = bus.FRM_START ? '0 : shift_q;
    cnt_base   = bus.FRM_START ? '0 : cnt_q;
    shift_d    = shift_base;
    cnt_d      = cnt_base;
    shift_nxt  = shift_base;
    if (bus.FRM_START) begin
      overrun_d = 1'b0;
    end
    if (par_vld_q && bus.PAR_RDY) begin
      par_vld_d = 1'b0;
    end
    if (LSB_FIRST) begin
      shift_nxt = {bus.SER_IP, shift_base[DATA_W-1:1]};
    end else begin
      shift_nxt = {shift_base[DATA_W-2:0], bus.SER_IP};
    end
    if (word_drop) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (bit_vld) begin
      shift_d = shift_nxt;
      if (bit_cnt_t'(cnt_base) == WORD_LAST) begin
        cnt_d = '0;
        // Load when the holder is empty or is being consumed this same cycle;
        // otherwise the new word is dropped and the held one kept.
        if (!par_vld_q || bus.PAR_RDY) begin
          par_op_d  = shift_nxt;
          par_vld_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      par_op_q  <= '0;
      par_vld_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_op_q  <= par_op_d;
      par_vld_q <= par_vld_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.PAR_OP    = par_op_q;
  assign bus.PAR_VLD   = par_vld_q;
  assign bus.OVERRUN   = overrun_q;
  assign bus.STUFF_ERR = stuff_err;

endmodule
